sipo_rx: RTL and testbench

Serial-in/parallel-out receiver that sits directly downstream of the universal shift register. It consumes that register's s_out stream, which is LSB first, one bit per strobe. It reassembles N-bit words and presents them on a one-entry valid/ready output buffer with overrun detection. Bit gaps are allowed, and a flush aborts a partial frame.

---
 rtl/sipo_rx.sv | 144 ++++++++++++++
 tb/tb_sipo_rx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
`default_nettype none
// ============================================================================
// Module   : sipo_rx
// Brief    : Serial-in/parallel-out receiver. Reassembles LSB-first serial
//            bits into N-bit words. Words are presented through a one-entry
//            valid/ready buffer, and a sticky overrun flag reports dropped
//            words. Gaps between bits are allowed, and flush aborts a
//            partial frame.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_rx #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_in,
  input  logic          s_valid,
  input  logic          flush,
  output logic [N-1:0]  m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          busy,
  output logic [CW-1:0] bit_cnt,
  output logic          overrun,
  input  logic          clr_ovr
);

  // Frame state mirrors bit_cnt: IDLE when no bits are held, COLLECT otherwise.
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam logic [CW-1:0] c_LAST_BIT = CW'(N - 1);

  state_t          state_q, state_d;
  logic [N-1:0]    sh_q, sh_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    data_q, data_d;
  logic            valid_q, valid_d;
  logic            ovr_q, ovr_d;

  logic            w_accept;    // a serial bit is taken this cycle
  logic            w_complete;  // this bit finishes a word
  logic            w_pop;       // consumer takes the buffered word
  logic            w_drop;      // finished word has nowhere to go
  logic [N-1:0]    w_word;      // shift register including the current bit

  // Decode the per-cycle events. A flush cancels any bit in the same cycle.
  always_comb begin
    w_accept   = s_valid && !flush;
    w_word     = {s_in, sh_q[N-1:1]};
    w_complete = w_accept && (cnt_q == c_LAST_BIT);
    w_pop      = valid_q && m_ready;
    w_drop     = w_complete && valid_q && !m_ready;
  end

  // FSM next state: enter COLLECT on the first bit, leave on the Nth bit or a flush.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (flush || w_complete) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift register and bit counter. Bits enter at the MSB and move toward bit 0.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (flush) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (s_valid) begin
      sh_d = w_word;
      if (w_complete) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Output buffer. A completed word loads when the buffer is empty or is
  // popped in the same cycle. Otherwise the word is dropped and the held
  // data stays unchanged.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (w_complete && !w_drop) begin
      data_d  = w_word;
      valid_d = 1'b1;
    end else if (w_pop) begin
      valid_d = 1'b0;
    end
  end

  // Sticky overrun flag. If a drop and clr_ovr occur in the same cycle, the drop wins.
  always_comb begin
    ovr_d = ovr_q;
    if (w_drop) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end
  end

  // State registers with synchronous reset. Reset discards the partial frame and the buffered word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign m_data  = data_q;
  assign m_valid = valid_q;
  assign busy    = (state_q == COLLECT);
  assign bit_cnt = cnt_q;
  assign overrun = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_sipo_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo_rx
// Brief    : Self-checking bench for sipo_rx. Uses directed scenarios and a
//            randomized phase, and checks against a bit-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sipo_rx;
  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_in = 1'b0;
  logic          s_valid = 1'b0;
  logic          flush = 1'b0;
  logic [N-1:0]  m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          busy;
  logic [CW-1:0] bit_cnt;
  logic          overrun;
  logic          clr_ovr = 1'b0;

  sipo_rx #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_in    (s_in),
    .s_valid (s_valid),
    .flush   (flush),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .busy    (busy),
    .bit_cnt (bit_cnt),
    .overrun (overrun),
    .clr_ovr (clr_ovr)
  );

  always #5 clk = ~clk;

  // Reference model: the bits of the current frame in arrival order, plus the buffer.
  logic         bitq[$];
  logic [N-1:0] exp_data;
  logic         exp_valid;
  logic         exp_ovr;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("bit_cnt", 32'(bit_cnt), 32'(bitq.size()));
    chk("busy",    32'(busy),    32'(bitq.size() != 0));
    chk("m_valid", 32'(m_valid), 32'(exp_valid));
    chk("m_data",  32'(m_data),  32'(exp_data));
    chk("overrun", 32'(overrun), 32'(exp_ovr));
  endtask

  // Drive one cycle of inputs, advance the model, clock, then compare.
  task automatic step(input logic sv, input logic sin, input logic fl,
                      input logic rdy, input logic clr);
    logic         comp;
    logic [N-1:0] word;
    s_valid = sv; s_in = sin; flush = fl; m_ready = rdy; clr_ovr = clr;
    comp = 1'b0;
    word = '0;
    if (fl) begin
      bitq.delete();
    end else if (sv) begin
      bitq.push_back(sin);
      if (bitq.size() == N) begin
        comp = 1'b1;
        for (int i = 0; i < N; i++) word[i] = bitq[i];
        bitq.delete();
      end
    end
    if (comp && exp_valid && !rdy) begin
      exp_ovr = 1'b1;
    end else begin
      if (clr) exp_ovr = 1'b0;
      if (comp) begin
        exp_data  = word;
        exp_valid = 1'b1;
      end else if (exp_valid && rdy) begin
        exp_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_in = 1'b0; flush = 1'b0; m_ready = 1'b0; clr_ovr = 1'b0;
    bitq.delete();
    exp_data = '0; exp_valid = 1'b0; exp_ovr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
  endtask

  // Send a word LSB first. Optional random gaps. last_rdy is m_ready on the final bit.
  task automatic send_word(input logic [N-1:0] w, input bit gaps, input logic last_rdy);
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        int g;
        g = int'($urandom_range(0, 3));
        for (int k = 0; k < g; k++) step(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0);
      end
      step(1'b1, w[i], 1'b0, (i == N - 1) ? last_rdy : 1'b0, 1'b0);
    end
  endtask

  initial begin
    exp_data = '0; exp_valid = 1'b0; exp_ovr = 1'b0;

    // 1: reset state, then back-to-back 0xA5
    do_reset();
    chk("reset_m_data", 32'(m_data), 32'h0);
    send_word(8'hA5, 1'b0, 1'b0);
    chk("t1_data", 32'(m_data), 32'hA5);
    chk("t1_valid", 32'(m_valid), 32'h1);
    chk("t1_busy", 32'(busy), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_pop", 32'(m_valid), 32'h0);

    // 2: same frame with gaps
    send_word(8'hA5, 1'b1, 1'b0);
    chk("t2_data", 32'(m_data), 32'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 3: overrun
    send_word(8'h3C, 1'b0, 1'b0);
    send_word(8'hFF, 1'b0, 1'b0);
    chk("t3_data", 32'(m_data), 32'h3C);
    chk("t3_ovr", 32'(overrun), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_pop", 32'(m_valid), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_clr", 32'(overrun), 32'h0);

    // 4: same-cycle pop and load
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b1);
    chk("t4_valid", 32'(m_valid), 32'h1);
    chk("t4_data", 32'(m_data), 32'h22);
    chk("t4_ovr", 32'(overrun), 32'h0);

    // 5: flush with 0x22 still buffered
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
    chk("t5_cnt5", 32'(bit_cnt), 32'h5);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_flush_cnt", 32'(bit_cnt), 32'h0);
    chk("t5_flush_valid", 32'(m_valid), 32'h1);
    chk("t5_flush_data", 32'(m_data), 32'h22);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word(8'h5A, 1'b0, 1'b0);
    chk("t5_data", 32'(m_data), 32'h5A);

    // 5b: flush on the would-be Nth bit
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < N - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5b_no_word", 32'(m_valid), 32'h0);

    // 6: reset mid-frame with a word pending
    send_word(8'h77, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_cnt4", 32'(bit_cnt), 32'h4);
    do_reset();
    chk("t6_rst_valid", 32'(m_valid), 32'h0);
    chk("t6_rst_cnt", 32'(bit_cnt), 32'h0);
    send_word(8'hC3, 1'b0, 1'b0);
    chk("t6_data", 32'(m_data), 32'hC3);

    // Randomized phase against the model
    for (int c = 0; c < 600; c++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom),
           1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
